// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with a four-region slave decoder and a bus timeout.
// Grants round-robin, holds the grant for the whole cyc, and answers stalled strobes with an error.
module wb_arbiter #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         m0_cyc_i,
    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [3:0]   m0_sel_i,
    input  logic [29:0]  m0_adr_i,
    input  logic [31:0]  m0_dat_i,
    output logic [31:0]  m0_dat_o,
    output logic         m0_ack_o,
    output logic         m0_err_o,

    input  logic         m1_cyc_i,
    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [3:0]   m1_sel_i,
    input  logic [29:0]  m1_adr_i,
    input  logic [31:0]  m1_dat_i,
    output logic [31:0]  m1_dat_o,
    output logic         m1_ack_o,
    output logic         m1_err_o,

    output logic         s_cyc_o,
    output logic         s_we_o,
    output logic [3:0]   s_sel_o,
    output logic [29:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_stb_o,
    input  logic [3:0]   s_ack_i,
    input  logic [127:0] s_dat_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    state_t          state, state_nxt;
    logic            last, last_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;

    logic        g_cyc, g_stb, g_we;
    logic [3:0]  g_sel;
    logic [29:0] g_adr;
    logic [31:0] g_dat;
    logic [1:0]  region;
    logic        fwd, slv_ack, to_hit;
    logic [31:0] rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // A grant is only ever taken from IDLE, so every grant change passes through one idle cycle.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
            GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        case (state)
            GNT0: begin
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i;
                g_we  = m0_we_i;
                g_sel = m0_sel_i;
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
            end
            GNT1: begin
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i;
                g_we  = m1_we_i;
                g_sel = m1_sel_i;
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign region  = g_adr[29:28];
    assign fwd     = g_cyc & g_stb;
    assign slv_ack = fwd & s_ack_i[region];
    // A real ack in the timeout cycle takes priority over the error response.
    assign to_hit  = fwd & ~slv_ack & (tcnt == TO_VAL);
    assign rd      = to_hit ? 32'hFFFF_FFFF : s_dat_i[{region, 5'b0} +: 32];

    always_comb begin
        tcnt_nxt = tcnt + 1'b1;
        if (!fwd || slv_ack || to_hit) tcnt_nxt = '0;
    end

    always_comb begin
        s_cyc_o  = g_cyc;
        s_we_o   = g_we;
        s_sel_o  = g_sel;
        s_adr_o  = g_adr;
        s_dat_o  = g_dat;
        s_stb_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (fwd && !to_hit) s_stb_o[region] = 1'b1;
        if (state == GNT0) begin
            m0_ack_o = slv_ack | to_hit;
            m0_err_o = to_hit;
            m0_dat_o = rd;
        end
        if (state == GNT1) begin
            m1_ack_o = slv_ack | to_hit;
            m1_err_o = to_hit;
            m1_dat_o = rd;
        end
    end

endmodule
